branch_resolve_unit: RTL and testbench

- Execute-stage consumer of the branch comparator outputs (breq/brlt).
- Combines breq/brlt with the EX-stage instruction's opcode/funct3 to decide taken/not-taken for branches, JAL and JALR.
- Owns the fetch PC register: redirects it on a taken transfer, flushes younger IF/ID instructions, inserts a one-cycle refetch bubble.
- Traps misaligned targets and keeps branch statistics counters.

---
 rtl/branch_resolve_unit_pkg.sv | 24 ++
 rtl/branch_resolve_unit_decode.sv | 50 +++++
 rtl/branch_resolve_unit.sv | 112 +++++++++++
 tb/tb_branch_resolve_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared opcode/funct3 constants and fetch-state encoding
// for the branch resolve unit and its decoder.
package branch_resolve_unit_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_RUN    = 2'd0;
  localparam fetch_state_t ST_BUBBLE = 2'd1;
  localparam fetch_state_t ST_HALT   = 2'd2;

  localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;

endpackage

// File: rtl/branch_resolve_unit_decode.sv
// Combinational taken decode for branches and jumps
// from opcode/funct3 and the comparator flags.
module branch_taken_decode
  import branch_resolve_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       breq,
  input  logic       brlt,
  output logic       taken,
  output logic       is_branch,
  output logic       is_jump
);

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    unique case (1'b1)
      (opcode == OPCODE_BRANCH): begin
        case (funct3)
          FUNCT3_BEQ: begin
            is_branch = 1'b1;
            taken     = breq;
          end
          FUNCT3_BNE: begin
            is_branch = 1'b1;
            taken     = !breq;
          end
          FUNCT3_BLT, FUNCT3_BLTU: begin
            is_branch = 1'b1;
            taken     = brlt;
          end
          FUNCT3_BGE, FUNCT3_BGEU: begin
            is_branch = 1'b1;
            taken     = !brlt;
          end
          default: ;
        endcase
      end
      (opcode == OPCODE_JAL),
      (opcode == OPCODE_JALR): begin
        is_jump = 1'b1;
        taken   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: owns the fetch PC, redirects,
// flushes, traps misaligned targets and counts branches.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = BASEADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  input  logic [6:0]        ex_opcode_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [AWIDTH-1:0] ex_pc_i,
  input  logic [DWIDTH-1:0] ex_imm_i,
  input  logic [DWIDTH-1:0] ex_rs1_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  input  logic              stall_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic              fetch_valid_o,
  output logic              redirect_o,
  output logic [AWIDTH-1:0] target_o,
  output logic              flush_o,
  output logic              misalign_o,
  output logic              halted_o,
  output logic [31:0]       br_count_o,
  output logic [31:0]       taken_count_o
);

  fetch_state_t      state;
  logic              taken;
  logic              is_branch;
  logic              is_jump;
  logic [DWIDTH-1:0] jalr_sum;
  logic [AWIDTH-1:0] jalr_tgt;
  logic [AWIDTH-1:0] target;
  logic              run;
  logic              resolve;
  logic              aligned;
  logic              cnt_en;

  branch_taken_decode u_decode (
    .opcode    (ex_opcode_i),
    .funct3    (ex_funct3_i),
    .breq      (breq_i),
    .brlt      (brlt_i),
    .taken     (taken),
    .is_branch (is_branch),
    .is_jump   (is_jump)
  );

  always_comb begin
    jalr_sum = ex_rs1_i + ex_imm_i;
    jalr_tgt = jalr_sum[AWIDTH-1:0] & ~AWIDTH'(1);
    if (is_jump && ex_opcode_i == OPCODE_JALR)
      target = jalr_tgt;
    else
      target = ex_pc_i + ex_imm_i[AWIDTH-1:0];
  end

  assign run     = (state == ST_RUN);
  assign resolve = run && ex_valid_i && taken;
  assign aligned = (target[1:0] == 2'b00);
  assign cnt_en  = run && ex_valid_i && is_branch;

  // Gate with reset so nothing leaks out while the PC is being forced
  assign redirect_o    = !reset && resolve && aligned;
  assign flush_o       = redirect_o;
  assign target_o      = reset ? '0 : target;
  assign fetch_valid_o = run;
  assign halted_o      = (state == ST_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      pc_o       <= BASEADDR;
      misalign_o <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (resolve && aligned) begin
            pc_o  <= target;
            state <= ST_BUBBLE;
          end else if (resolve) begin
            misalign_o <= 1'b1;
            state      <= ST_HALT;
          end else if (!stall_i) begin
            pc_o <= pc_o + AWIDTH'(4);
          end
        end
        ST_BUBBLE: state <= ST_RUN;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count_o    <= '0;
      taken_count_o <= '0;
    end else if (cnt_en) begin
      if (br_count_o != '1)
        br_count_o <= br_count_o + 32'd1;
      if (taken && taken_count_o != '1)
        taken_count_o <= taken_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Random + directed bench for branch_resolve_unit against
// a cycle-level behavioural model of the fetch unit.
module tb_branch_resolve_unit;

  localparam logic [6:0]  OP_BR   = 7'h63;
  localparam logic [6:0]  OP_JAL  = 7'h6f;
  localparam logic [6:0]  OP_JALR = 7'h67;
  localparam logic [6:0]  OP_ALU  = 7'h33;
  localparam logic [31:0] BASE    = 32'h0100_0000;
  localparam logic [31:0] MAXC    = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] pc_in;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        eq;
  logic        lt;
  logic        stall;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        redirect_o;
  logic [31:0] target_o;
  logic        flush_o;
  logic        misalign_o;
  logic        halted_o;
  logic [31:0] br_count_o;
  logic [31:0] taken_count_o;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid_i    (valid),
    .ex_opcode_i   (op),
    .ex_funct3_i   (f3),
    .ex_pc_i       (pc_in),
    .ex_imm_i      (imm),
    .ex_rs1_i      (rs1),
    .breq_i        (eq),
    .brlt_i        (lt),
    .stall_i       (stall),
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .redirect_o    (redirect_o),
    .target_o      (target_o),
    .flush_o       (flush_o),
    .misalign_o    (misalign_o),
    .halted_o      (halted_o),
    .br_count_o    (br_count_o),
    .taken_count_o (taken_count_o)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_br;
  logic [31:0] m_tk;
  logic        m_mis;
  int          m_mode;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    valid = 1'b0; op = OP_ALU; f3 = 3'd0; pc_in = BASE;
    imm = 32'd0; rs1 = 32'd0; eq = 1'b0; lt = 1'b0; stall = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = BASE; m_br = 0; m_tk = 0; m_mis = 0; m_mode = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Check one cycle against the model, then advance it past the edge
  task automatic step();
    logic        br_ok, cond, jmp, res, al;
    logic [31:0] tgt;
    #1;
    br_ok = (op == OP_BR) && f3 != 3'd2 && f3 != 3'd3;
    case (f3)
      3'd0:       cond = eq;
      3'd1:       cond = !eq;
      3'd4, 3'd6: cond = lt;
      default:    cond = !lt;
    endcase
    cond = cond && br_ok;
    jmp  = (op == OP_JAL) || (op == OP_JALR);
    tgt  = (op == OP_JALR) ? ((rs1 + imm) & ~32'd1) : (pc_in + imm);
    res  = (m_mode == 0) && valid && (cond || jmp);
    al   = (tgt[1:0] == 2'b00);
    chk("pc", pc_o, m_pc);
    chk("fetch_valid", 32'(fetch_valid_o), 32'(m_mode == 0));
    chk("redirect", 32'(redirect_o), 32'(res && al));
    chk("flush", 32'(flush_o), 32'(res && al));
    if (res && al) chk("target", target_o, tgt);
    chk("misalign", 32'(misalign_o), 32'(m_mis));
    chk("halted", 32'(halted_o), 32'(m_mode == 2));
    chk("br_count", br_count_o, m_br);
    chk("taken_count", taken_count_o, m_tk);
    @(posedge clk);
    if (m_mode == 0) begin
      if (valid && br_ok) begin
        if (m_br != MAXC) m_br++;
        if (cond && m_tk != MAXC) m_tk++;
      end
      if (res && al) begin
        m_pc = tgt; m_mode = 1;
      end else if (res) begin
        m_mis = 1'b1; m_mode = 2;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (m_mode == 1) begin
      m_mode = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #2;
    chk("rst_pc", pc_o, BASE);
    chk("rst_br", br_count_o, 32'd0);
    do_reset();

    // sequential fetch after reset
    for (int i = 0; i < 3; i++) begin
      chk("seq_pc", pc_o, BASE + 32'(4 * i));
      step();
    end

    // BEQ taken, then refetch bubble
    valid = 1'b1; op = OP_BR; f3 = 3'd0; pc_in = 32'h0100_0010;
    imm = 32'h20; eq = 1'b1;
    #1 chk("beq_target", target_o, 32'h0100_0030);
    step();
    idle();
    chk("beq_pc", pc_o, 32'h0100_0030);
    chk("beq_bubble", 32'(fetch_valid_o), 32'd0);
    step();
    step();
    chk("beq_br", br_count_o, 32'd1);
    chk("beq_tk", taken_count_o, 32'd1);

    // BGE not taken under stall
    valid = 1'b1; op = OP_BR; f3 = 3'd5; lt = 1'b1; stall = 1'b1;
    step();

    // JALR redirects despite stall
    valid = 1'b1; op = OP_JALR; rs1 = 32'h0100_0101; imm = 32'd0;
    stall = 1'b1;
    #1 chk("jalr_target", target_o, 32'h0100_0100);
    step();
    idle();
    step();

    // misaligned BNE halts, later inputs ignored
    valid = 1'b1; op = OP_BR; f3 = 3'd1; eq = 1'b0;
    pc_in = 32'h0100_0000; imm = 32'h6;
    step();
    chk("mis_halt", 32'(halted_o), 32'd1);
    op = OP_JAL; imm = 32'h40;
    for (int i = 0; i < 3; i++) step();

    // async reset during the bubble
    do_reset();
    valid = 1'b1; op = OP_JAL; pc_in = 32'h0100_0200; imm = 32'h100;
    step();
    chk("pre_rst_bubble", 32'(fetch_valid_o), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", pc_o, BASE);
    chk("arst_redirect", 32'(redirect_o), 32'd0);
    chk("arst_valid", 32'(fetch_valid_o), 32'd1);
    chk("arst_br", br_count_o, 32'd0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: op = OP_BR;
        4:          op = OP_JAL;
        5:          op = OP_JALR;
        default:    op = OP_ALU;
      endcase
      f3    = 3'($urandom);
      eq    = 1'($urandom);
      lt    = 1'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      pc_in = $urandom & ~32'd3;
      imm   = 32'($signed(12'($urandom))) & ~32'd3;
      rs1   = $urandom & ~32'd2;
      if ($urandom_range(0, 15) == 0) begin
        imm = imm | 32'($urandom_range(1, 3));
        rs1 = rs1 | 32'd2;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
